// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: mul_control bit positions,
// FSM state encoding and the divider iteration count.
package muldiv_unit_pkg;

   localparam int MC_MULT  = 0;
   localparam int MC_MULTU = 1;
   localparam int MC_DIV   = 2;
   localparam int MC_DIVU  = 3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_FIX  = 2'd3;

   localparam int DIV_ITERS = 32;
   localparam int DIV_CNT_W = $clog2(DIV_ITERS);

   typedef enum logic [2:0] {
      OP_NONE,
      OP_MULT,
      OP_MULTU,
      OP_DIV,
      OP_DIVU
   } op_t;

   // Several bits set resolve toward the lowest bit position.
   function automatic op_t decode_op(input logic [3:0] mc);
      if (mc[MC_MULT])  return OP_MULT;
      if (mc[MC_MULTU]) return OP_MULTU;
      if (mc[MC_DIV])   return OP_DIV;
      if (mc[MC_DIVU])  return OP_DIVU;
      return OP_NONE;
   endfunction

   function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle.
// done is high during the final iteration cycle; results are stable once busy drops.
module div_core
   import muldiv_unit_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        abort,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic [31:0]          rem;
   logic [31:0]          quo;
   logic [31:0]          dvsr;
   logic [DIV_CNT_W-1:0] cnt;
   logic [32:0]          shifted;
   logic [32:0]          diff;

   // 33 bits are enough: bit 32 of diff is the trial-subtract sign.
   assign shifted = {rem, quo[31]};
   assign diff    = shifted - {1'b0, dvsr};
   assign done    = busy && (cnt == DIV_CNT_W'(DIV_ITERS - 1));

   always_ff @(posedge clk) begin
      if (!resetn) begin
         busy <= 1'b0;
         rem  <= '0;
         quo  <= '0;
         dvsr <= '0;
         cnt  <= '0;
      end else if (abort) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         rem  <= '0;
         quo  <= dividend;
         dvsr <= divisor;
         cnt  <= '0;
      end else if (busy) begin
         rem  <= diff[32] ? shifted[31:0] : diff[31:0];
         quo  <= {quo[30:0], ~diff[32]};
         cnt  <= cnt + 1'b1;
         if (done) busy <= 1'b0;
      end
   end

   assign quotient  = quo;
   assign remainder = rem;

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide execution unit owning HI/LO; multi-cycle multiplier,
// iterative divider with sign fix-up, mthi/mtlo writes and flush.
//
// state | meaning
// IDLE  | ready; accepts mul/div or mthi/mtlo
// MUL   | multiplier counting down MUL_CYCLES, writes HI/LO at terminal count
// DIV   | div_core iterating on operand magnitudes
// FIX   | apply signs / divide-by-zero result, write HI/LO
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int MUL_CYCLES = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  mul_control,
   input  logic [1:0]  hilo_we,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [1:0] MUL_LOAD = 2'(MUL_CYCLES - 1);

   logic [1:0]  state;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_signed;
   logic [1:0]  mul_cnt;
   logic        div_neg_q;
   logic        div_neg_r;
   logic        div_zero;
   logic [31:0] div_a_raw;

   op_t         op;
   logic        accept;
   logic        div_start;
   logic        div_signed;
   logic        core_busy;
   logic        core_done;
   logic [31:0] core_q;
   logic [31:0] core_r;
   logic [32:0] ext_a33;
   logic [32:0] ext_b33;
   logic [63:0] product;
   logic [31:0] fix_q;
   logic [31:0] fix_r;

   assign op         = decode_op(mul_control);
   assign in_ready   = (state == ST_IDLE);
   assign accept     = in_valid && in_ready && !flush;
   assign div_signed = (op == OP_DIV);
   assign div_start  = accept && ((op == OP_DIV) || (op == OP_DIVU));
   assign busy       = (state != ST_IDLE) || core_busy;

   // Low 64 bits of the product of 33-bit extended operands; the upper
   // extension only needs to replicate bit 32.
   assign ext_a33 = {mul_signed & mul_a[31], mul_a};
   assign ext_b33 = {mul_signed & mul_b[31], mul_b};
   assign product = {{31{ext_a33[32]}}, ext_a33} * {{31{ext_b33[32]}}, ext_b33};

   assign fix_q = div_neg_q ? (32'd0 - core_q) : core_q;
   assign fix_r = div_neg_r ? (32'd0 - core_r) : core_r;

   div_core u_div_core (
      .clk       (clk),
      .resetn    (resetn),
      .abort     (flush),
      .start     (div_start),
      .dividend  (abs32(src_a, div_signed)),
      .divisor   (abs32(src_b, div_signed)),
      .busy      (core_busy),
      .done      (core_done),
      .quotient  (core_q),
      .remainder (core_r)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         hi         <= '0;
         lo         <= '0;
         done       <= 1'b0;
         mul_a      <= '0;
         mul_b      <= '0;
         mul_signed <= 1'b0;
         mul_cnt    <= '0;
         div_neg_q  <= 1'b0;
         div_neg_r  <= 1'b0;
         div_zero   <= 1'b0;
         div_a_raw  <= '0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (accept) begin
                     case (op)
                        OP_MULT, OP_MULTU: begin
                           state      <= ST_MUL;
                           mul_a      <= src_a;
                           mul_b      <= src_b;
                           mul_signed <= (op == OP_MULT);
                           mul_cnt    <= MUL_LOAD;
                        end
                        OP_DIV, OP_DIVU: begin
                           state     <= ST_DIV;
                           div_neg_q <= div_signed && (src_a[31] ^ src_b[31]);
                           div_neg_r <= div_signed && src_a[31];
                           div_zero  <= (src_b == 32'd0);
                           div_a_raw <= src_a;
                        end
                        default: begin
                           if (hilo_we[0]) hi <= src_a;
                           if (hilo_we[1]) lo <= src_a;
                        end
                     endcase
                  end
               end
               ST_MUL: begin
                  if (mul_cnt == 2'd0) begin
                     hi    <= product[63:32];
                     lo    <= product[31:0];
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     mul_cnt <= mul_cnt - 1'b1;
                  end
               end
               ST_DIV: begin
                  if (core_done) state <= ST_FIX;
               end
               ST_FIX: begin
                  // Divide by zero reports the untouched dividend, not its magnitude.
                  if (div_zero) begin
                     hi <= div_a_raw;
                     lo <= 32'hFFFF_FFFF;
                  end else begin
                     hi <= fix_r;
                     lo <= fix_q;
                  end
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multiply/divide execution unit sitting directly downstream of the R-type decoder. It consumes the decoder's 4-bit mul_control and the mthi/mtlo write targets.
- Owns the architectural HI/LO registers.
- mult/multu take MUL_CYCLES cycles; div/divu use an iterative radix-2 restoring divider.
- Exposes busy/in_ready so the pipeline can stall mfhi/mflo and new mul/div issue.

Parameters:
- MUL_CYCLES, 1, cycles spent in MUL state (1..4); lets the multiplier be retimed.
- DIV_ITERS, 32, divider iterations (one quotient bit per cycle); fixed for 32-bit data.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- in_valid  in  1  an operation is presented this cycle
- in_ready  out  1  unit can accept (state==IDLE)
- mul_control  in  4  one-hot op: bit0 mult, bit1 multu, bit2 div, bit3 divu; 0 = none
- hilo_we  in  2  bit0 mthi, bit1 mtlo
- src_a  in  32  rs value (dividend / multiplicand / mthi-mtlo data)
- src_b  in  32  rt value (divisor / multiplier)
- flush  in  1  cancel in-flight operation (exception/branch squash)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse: HI/LO just updated by a mul/div
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE, hi=0, lo=0, done=0, operand/counter regs=0. Reset overrides everything, including mid-divide.
- Accept: in_valid && in_ready && !flush at posedge.
  - If mul_control != 0, the op is latched and hilo_we is ignored.
  - mul_control with more than one bit set is resolved by priority bit0 > bit1 > bit2 > bit3.
  - mul_control==0 with hilo_we != 0: hi<=src_a (bit0) and/or lo<=src_a (bit1) at that edge. State stays IDLE; no done pulse.
  - Inputs while in_ready=0 are ignored; no queuing.
- States: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL on accepted mult/multu.
  - IDLE -> DIV on accepted div/divu.
- MUL:
  - Signed (mult) or unsigned (multu) 32x32 -> 64 product.
  - Counter runs MUL_CYCLES cycles; at the final edge {hi,lo}<=product and state -> IDLE.
  - With MUL_CYCLES=1, accept at edge T0 gives HI/LO updated at T1.
- DIV:
  - At accept, latch |a|, |b| (for div; raw values for divu), the sign of a, the sign of a^b, and cnt=0.
  - Each cycle: shift the remainder:quotient pair left 1, trial-subtract divisor, set quotient bit if non-negative.
  - After DIV_ITERS cycles -> FIX.
- FIX (1 cycle):
  - Apply signs: quotient negated if a^b negative; remainder takes the sign of the dividend (truncation toward zero).
  - Write lo<=quotient, hi<=remainder. State -> IDLE.
  - Total: accept at T0, HI/LO written at T33.
- Divide by zero (src_b==0, either signedness): lo<=32'hFFFFFFFF, hi<=src_a (original, unsigned-unmodified). Same 33-cycle timing.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- done: asserted for exactly one cycle, the cycle after the edge that wrote HI/LO. Never asserted for mthi/mtlo or flushed ops.
- flush: highest priority after reset.
  - In any state: next state IDLE, HI/LO unchanged, no done.
  - A flush in an accept cycle suppresses the accept, including mthi/mtlo.
- hi/lo are register outputs. During busy they hold the pre-operation values; the pipeline stalls mfhi/mflo on busy.
- Arithmetic: all internal remainder math is 33-bit to hold the trial-subtract sign. Products are computed full 64-bit via sign/zero extension to 33 bits.

Decomposition:
- Shared package (in define.v alongside the existing mul_control codes):
  - mul_control bit positions (MC_MULT=0, MC_MULTU=1, MC_DIV=2, MC_DIVU=3)
  - state encoding (IDLE/MUL/DIV/FIX)
  - DIV_ITERS
- One sub-module: div_core.
  - Unsigned iterative restoring divider with start/busy/done, quotient and remainder.
  - muldiv_unit handles sign fixing, divide-by-zero, the multiplier, HI/LO and flush.

Test Plan:
- mult a=0xFFFFFFFF b=2 -> at T1 hi=0xFFFFFFFF lo=0xFFFFFFFE, done at T1 only. multu same operands -> hi=0x00000001 lo=0xFFFFFFFE.
- div a=0xFFFFFFF9(-7) b=2 -> busy 33 cycles, lo=0xFFFFFFFD hi=0xFFFFFFFF, done one cycle. divu 7/2 -> lo=3 hi=1.
- divu 5/0 -> lo=0xFFFFFFFF hi=5. div 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
- mthi 0x12345678 presented mid-divide -> ignored (in_ready=0). Re-presented in IDLE -> hi=0x12345678 next cycle, lo unchanged, no done.
- Start div 100/7 from hi=lo=0xAA, flush in DIV cycle 10 -> IDLE next cycle, hi=lo=0xAA, no done. New mult accepted the following cycle completes normally.
- resetn=0 during DIV cycle 20 -> hi=lo=0, busy=0, done=0 next cycle. in_valid+mul_control=4'b0101 -> executes as mult.
